// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared MIPS register-file types and constants
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int REG_ZERO           = 0;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode/writeback bundle for the register file
interface register_file_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  reserveEn;
  logic [ADDR_WIDTH-1:0] reserveRegister;
  logic                  busy1;
  logic                  busy2;
  logic                  stall;

  modport master (
    output regWrite, writeRegister, writeData,
    output readRegister1, readRegister2,
    output reserveEn, reserveRegister,
    input  a, b, busy1, busy2, stall
  );

  modport slave (
    input  regWrite, writeRegister, writeData,
    input  readRegister1, readRegister2,
    input  reserveEn, reserveRegister,
    output a, b, busy1, busy2, stall
  );

endinterface

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - busy bits for pending writebacks
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  localparam bit BYP = (BYPASS != 0);

  logic [DEPTH-1:0] busy_q;

  // Set is applied after clear so a newer producer wins on a same-register collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      if (clr_en && clr_addr != ZERO) busy_q[clr_addr] <= 1'b0;
      if (set_en && set_addr != ZERO) busy_q[set_addr] <= 1'b1;
    end
  end

  logic mask1, mask2;

  always_comb begin
    mask1 = BYP && clr_en && (clr_addr == rd_addr1);
    mask2 = BYP && clr_en && (clr_addr == rd_addr2);
    busy1 = !reset && (rd_addr1 != ZERO) && busy_q[rd_addr1] && !mask1;
    busy2 = !reset && (rd_addr2 != ZERO) && busy_q[rd_addr2] && !mask2;
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - MIPS GPR file with bypass and load scoreboard
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input logic           clk,
  input logic           reset,
  register_file_if.slave rf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  localparam bit BYP = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic                  fwd1, fwd2;
  logic                  sb_busy1, sb_busy2;

  assign wr_en = rf.regWrite && (rf.writeRegister != ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[rf.writeRegister] <= rf.writeData;
    end
  end

  // wr_en already excludes r0, so forwarding never leaks data onto a zero-register read.
  always_comb begin
    fwd1 = BYP && wr_en && (rf.writeRegister == rf.readRegister1);
    fwd2 = BYP && wr_en && (rf.writeRegister == rf.readRegister2);
    rf.a = '0;
    rf.b = '0;
    if (!reset) begin
      rf.a = fwd1 ? rf.writeData : mem[rf.readRegister1];
      rf.b = fwd2 ? rf.writeData : mem[rf.readRegister2];
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rf.reserveEn),
    .set_addr (rf.reserveRegister),
    .clr_en   (wr_en),
    .clr_addr (rf.writeRegister),
    .rd_addr1 (rf.readRegister1),
    .rd_addr2 (rf.readRegister2),
    .busy1    (sb_busy1),
    .busy2    (sb_busy2)
  );

  assign rf.busy1 = sb_busy1;
  assign rf.busy2 = sb_busy2;
  assign rf.stall = sb_busy1 | sb_busy2;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed scoreboard bench for register_file
module tb_register_file;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        regWrite, reserveEn;
  logic [4:0]  wr, rr1, rr2, rs;
  logic [31:0] wd;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();

  assign bus1.regWrite = regWrite;        assign bus0.regWrite = regWrite;
  assign bus1.writeRegister = wr;         assign bus0.writeRegister = wr;
  assign bus1.writeData = wd;             assign bus0.writeData = wd;
  assign bus1.readRegister1 = rr1;        assign bus0.readRegister1 = rr1;
  assign bus1.readRegister2 = rr2;        assign bus0.readRegister2 = rr2;
  assign bus1.reserveEn = reserveEn;      assign bus0.reserveEn = reserveEn;
  assign bus1.reserveRegister = rs;       assign bus0.reserveRegister = rs;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .rf(bus1.slave));
  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .rf(bus0.slave));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic take(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL queue_empty observed=%h expected=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic rw, input logic [4:0] w, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic re, input logic [4:0] rsv);
    regWrite = rw; wr = w; wd = d; rr1 = r1; rr2 = r2; reserveEn = re; rs = rsv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    // Activity during reset must be ignored and outputs forced low.
    drive(1, 5, 32'hFFFF_FFFF, 5, 5, 1, 5);
    push("rst_a_forced", 32'h0); push("rst_stall_forced", 32'h0);
    @(negedge clk); take(bus1.a); take({31'b0, bus1.stall});
    step();
    reset = 1'b0;
    drive(0, 0, 0, 5, 5, 0, 0);
    push("rst_write_ignored", 32'h0); push("rst_reserve_ignored", 32'h0);
    @(negedge clk); take(bus1.a); take({31'b0, bus1.busy1});

    for (int i = 0; i < 32; i++) begin
      step();
      drive(0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
      push($sformatf("rst_a_r%0d", i), 32'h0);
      push($sformatf("rst_b_r%0d", 31 - i), 32'h0);
      push($sformatf("rst_stall_r%0d", i), 32'h0);
      @(negedge clk); take(bus1.a); take(bus1.b); take({31'b0, bus1.stall});
    end

    step();
    drive(1, 5, 32'hDEAD_BEEF, 5, 5, 0, 0);
    push("r5_bypass_a", 32'hDEAD_BEEF); push("r5_nobypass_a", 32'h0);
    @(negedge clk); take(bus1.a); take(bus0.a);
    step();
    drive(0, 0, 0, 5, 5, 0, 0);
    push("r5_a", 32'hDEAD_BEEF); push("r5_b", 32'hDEAD_BEEF);
    push("r5_a_nb", 32'hDEAD_BEEF); push("r5_b_nb", 32'hDEAD_BEEF);
    @(negedge clk); take(bus1.a); take(bus1.b); take(bus0.a); take(bus0.b);

    step();
    drive(1, 0, 32'h1234, 0, 0, 0, 0);
    push("r0_no_bypass", 32'h0);
    @(negedge clk); take(bus1.a);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    push("r0_reads_zero", 32'h0); push("r0_reads_zero_nb", 32'h0);
    @(negedge clk); take(bus1.a); take(bus0.b);

    step();
    drive(1, 7, 32'hA5A5_A5A5, 7, 0, 0, 0);
    push("r7_bypass", 32'hA5A5_A5A5); push("r7_old_nb", 32'h0);
    @(negedge clk); take(bus1.a); take(bus0.a);
    step();
    drive(0, 0, 0, 7, 0, 0, 0);
    push("r7_next_nb", 32'hA5A5_A5A5);
    @(negedge clk); take(bus0.a);

    step();
    drive(0, 0, 0, 0, 9, 1, 9);
    push("r9_busy_not_yet", 32'h0);
    @(negedge clk); take({31'b0, bus1.busy2});
    step();
    drive(0, 0, 0, 0, 9, 0, 0);
    push("r9_busy2", 32'h1); push("r9_stall", 32'h1); push("r9_stall_nb", 32'h1);
    @(negedge clk); take({31'b0, bus1.busy2}); take({31'b0, bus1.stall}); take({31'b0, bus0.stall});
    step();
    drive(1, 9, 32'h77, 0, 9, 0, 0);
    push("r9_wb_stall", 32'h0); push("r9_wb_b", 32'h77);
    push("r9_wb_stall_nb", 32'h1); push("r9_wb_b_nb", 32'h0);
    @(negedge clk); take({31'b0, bus1.stall}); take(bus1.b); take({31'b0, bus0.stall}); take(bus0.b);
    step();
    drive(0, 0, 0, 0, 9, 0, 0);
    push("r9_after_stall_nb", 32'h0); push("r9_after_b_nb", 32'h77);
    @(negedge clk); take({31'b0, bus0.stall}); take(bus0.b);

    step();
    drive(1, 3, 32'h33, 3, 0, 1, 3);
    step();
    drive(0, 0, 0, 3, 0, 0, 0);
    push("r3_data", 32'h33); push("r3_set_wins", 32'h1); push("r3_set_wins_nb", 32'h1);
    @(negedge clk); take(bus1.a); take({31'b0, bus1.busy1}); take({31'b0, bus0.busy1});
    step();
    drive(1, 3, 32'h34, 3, 0, 0, 0);
    push("r3_clear_bypass", 32'h0); push("r3_clear_raw_nb", 32'h1);
    @(negedge clk); take({31'b0, bus1.busy1}); take({31'b0, bus0.busy1});
    step();
    drive(0, 0, 0, 3, 0, 1, 0);
    push("r3_cleared_nb", 32'h0);
    @(negedge clk); take({31'b0, bus0.busy1});
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    push("r0_not_busy", 32'h0); push("r0_no_stall", 32'h0);
    @(negedge clk); take({31'b0, bus1.busy1}); take({31'b0, bus1.stall});

    step(); drive(1, 4, 32'h44, 0, 0, 0, 0);
    step(); drive(1, 6, 32'h66, 0, 0, 0, 0);
    step(); drive(0, 0, 0, 0, 0, 1, 4);
    step(); drive(0, 0, 0, 0, 0, 1, 6);
    step();
    drive(0, 0, 0, 4, 6, 0, 0);
    push("r4_busy", 32'h1); push("r6_busy", 32'h1); push("r4_data", 32'h44); push("r6_data", 32'h66);
    @(negedge clk); take({31'b0, bus1.busy1}); take({31'b0, bus1.busy2}); take(bus1.a); take(bus1.b);
    step();
    reset = 1'b1;
    push("mid_rst_a", 32'h0); push("mid_rst_stall", 32'h0);
    @(negedge clk); take(bus1.a); take({31'b0, bus1.stall});
    step();
    reset = 1'b0;
    push("post_rst_r4", 32'h0); push("post_rst_r6", 32'h0); push("post_rst_stall", 32'h0);
    @(negedge clk); take(bus1.a); take(bus1.b); take({31'b0, bus1.stall});
    step();
    drive(1, 4, 32'h99, 4, 6, 0, 0);
    push("post_rst_wb_stall", 32'h0);
    @(negedge clk); take({31'b0, bus1.stall});
    step();
    drive(0, 0, 0, 4, 6, 0, 0);
    push("post_rst_r4_new", 32'h99); push("post_rst_wb_stall_nb", 32'h0);
    @(negedge clk); take(bus1.a); take({31'b0, bus0.stall});

    if (exp_q.size() != 0) begin
      n_bad++;
      $error("FAIL queue_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Clocked, parametrised MIPS general-purpose register file with two asynchronous read ports, one synchronous write port, a hardwired zero register, write-to-read bypass, and an integrated busy-bit scoreboard for pending multi-cycle writebacks such as loads. It sits between decode (read addresses, reservations) and writeback (write port). It supplies operands `a`/`b` to the ALU. It also raises `stall` when decode needs a register whose producer has not yet written back.

## Interface
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: register address width; depth = 2**ADDR_WIDTH.
- `BYPASS`, 1: 1 enables same-cycle write-to-read forwarding; 0 reads array contents only.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; clears array and scoreboard.
- `regWrite` input 1: write enable for the current cycle.
- `writeRegister` input ADDR_WIDTH: write address.
- `writeData` input DATA_WIDTH: write data.
- `readRegister1` input ADDR_WIDTH: read port 1 address.
- `readRegister2` input ADDR_WIDTH: read port 2 address.
- `a` output DATA_WIDTH: read port 1 data (combinational).
- `b` output DATA_WIDTH: read port 2 data (combinational).
- `reserveEn` input 1: marks `reserveRegister` busy (pending writeback).
- `reserveRegister` input ADDR_WIDTH: register to reserve.
- `busy1`, `busy2` output 1: busy bit of `readRegister1` / `readRegister2`.
- `stall` output 1: `busy1 | busy2`.

## Operation
- Array: 2**ADDR_WIDTH entries of DATA_WIDTH. Register 0 always reads 0. Writes to 0 are dropped. Reservations of 0 are dropped, and `busy` for address 0 is always 0.
- Write: the addressed entry takes `writeData` at the rising edge when `regWrite=1`, `reset=0`, and `writeRegister!=0`.
- Read: `a = (BYPASS && regWrite && writeRegister==readRegister1 && readRegister1!=0) ? writeData : array[readRegister1]`. `b` is the same for port 2. Both ports may address the same register.
- Scoreboard: one busy bit per register.
  - Set on the edge when `reserveEn=1`.
  - Cleared on the edge when `regWrite=1` to that address.
  - If both events target the same register in one cycle, set wins (newer producer supersedes).
  - A write to a non-busy register is legal and leaves its busy bit at 0.
- Busy is reported from registered state, except that a same-cycle `regWrite` to the read address masks the busy bit when `BYPASS=1`, since the data is forwarded. With `BYPASS=0`, busy is the raw bit.
- `stall` is purely combinational from `busy1`/`busy2`. The block never holds its own inputs; decode holds on `stall`.
- Reset:
  - All array entries and busy bits go to 0 on the edge.
  - While `reset=1`, `a`, `b`, `busy1`, `busy2` and `stall` are forced to 0, and writes and reservations that cycle are ignored.
  - Reset asserted mid-operation discards any outstanding reservations. A writeback arriving after reset then writes normally with no busy bit to clear.

## Timing
- Read latency 0 cycles (combinational from addresses and array state).
- Write latency 1 edge: data is visible through the array the cycle after `regWrite`, and in the same cycle through bypass when `BYPASS=1`.
- Reservation visible on `busy*`/`stall` the cycle after `reserveEn`.
- Clearing: with `BYPASS=1`, `busy*` falls in the writeback cycle itself. With `BYPASS=0`, it falls one cycle later.
- Reset values: `a=0`, `b=0`, `busy1=0`, `busy2=0`, `stall=0`. All entries read 0 after reset.
- No multi-cycle state machine; the only state is the array and the busy vector, both updated once per edge.

## Structure
- Shared package `mips_pkg`:
  - `REG_ZERO` (address 0).
  - Default `DATA_WIDTH`/`ADDR_WIDTH` constants.
  - `reg_addr_t` / `word_t` typedefs, which the decode and writeback stages reuse.
- Sub-module `reg_scoreboard`: busy vector with set/clear priority, reset, and per-port lookup with the bypass mask. The top level holds the array, bypass muxes and zero-register handling.

## Test plan
- Reset then read all 32 addresses: `a=b=0` and `stall=0` for every address.
- Write `0xDEADBEEF` to r5; next cycle read r5 on both ports: `a=b=0xDEADBEEF`. Write `0x1234` to r0: r0 still reads 0.
- Same-cycle bypass, `BYPASS=1`: `regWrite` r7=`0xA5A5A5A5` with `readRegister1=7` gives `a=0xA5A5A5A5` in that cycle. With `BYPASS=0`, `a` shows the old value, then `0xA5A5A5A5` next cycle.
- Load hazard: reserve r9; next cycle `readRegister2=9` gives `busy2=1`, `stall=1`. Writeback r9=`0x77` gives `stall=0` the same cycle (`BYPASS=1`) and `b=0x77`.
- Simultaneous `reserveEn` and `regWrite` both targeting r3: the data is written and r3 remains busy the next cycle. Reserving r0 leaves `busy` for r0 at 0.
- Reserve r4 and r6, then assert `reset` for 1 cycle: all busy bits are 0 and r4/r6 read 0. A later write to r4 leaves `stall=0`.
